// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder: block RAM port, LED/switch registers and interval timer.
// Optional feature macro: MIO_BUS_ERR_EN (sticky bus-error flag, 32'hBADA_DD00 on unmapped reads).
module mio_bus_responder #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RAM_LAT = 1,
    parameter logic [31:0] IO_BASE = 32'hF000_0000,
    parameter logic [15:0] RST_LED = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw,
    output logic [15:0]       led,
    output logic              INT,
    input  logic              INT_ACK
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAM_WAIT,
        S_DONE
    } state_e;

    localparam logic [25:0] OFF_LED  = 26'd0;
    localparam logic [25:0] OFF_SW   = 26'd1;
    localparam logic [25:0] OFF_CNT  = 26'd2;
    localparam logic [25:0] OFF_CMP  = 26'd3;
    localparam logic [25:0] OFF_CTRL = 26'd4;
    localparam logic [25:0] OFF_STAT = 26'd5;
    localparam logic [2:0]  LAT_LAST = 3'(RAM_LAT - 1);

`ifdef MIO_BUS_ERR_EN
    localparam logic [31:0] ERR_RDATA = 32'hBADA_DD00;
`else
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;
`endif

    state_e      state_q, state_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  lat_q, lat_d;

    logic [15:0] led_q, led_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        pend_q, pend_d;
    logic        int_q;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic        bus_err;

    logic        addr_unused;
    assign addr_unused = ^cpu_addr[1:0];

    // Decode of the incoming request (used in IDLE)
    logic        req_ram, req_io, req_hit;
    logic [25:0] req_off;
    logic [31:0] io_rdata;

    assign req_ram = (cpu_addr[31:28] == 4'h0);
    assign req_io  = (cpu_addr[31:28] == IO_BASE[31:28]);
    assign req_off = cpu_addr[27:2];

    // Decode of the latched request (used in DONE)
    logic        lat_io, lat_map;
    logic [25:0] lat_off;

    assign lat_off = addr_q[27:2];
    assign lat_io  = (addr_q[31:28] == IO_BASE[31:28]) && (lat_off <= OFF_STAT);
    assign lat_map = lat_io || (addr_q[31:28] == 4'h0);

    always_comb begin
        io_rdata = '0;
        req_hit  = req_io;
        case (req_off)
            OFF_LED:  io_rdata = {16'h0000, led_q};
            OFF_SW:   io_rdata = {16'h0000, sw_sync_q};
            OFF_CNT:  io_rdata = count_q;
            OFF_CMP:  io_rdata = compare_q;
            OFF_CTRL: io_rdata = {30'd0, ctrl_q};
            OFF_STAT: io_rdata = {23'd0, bus_err, 7'd0, pend_q};
            default:  req_hit  = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        lat_d     = lat_q;
        MIO_ready = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q[RAM_AW+1:2];
        ram_wdata = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                rdata_d = '0;
                if (cpu_req) begin
                    addr_d  = cpu_addr[31:2];
                    wdata_d = cpu_wdata;
                    we_d    = cpu_we;
                    if (req_ram) begin
                        // RAM sees the address in the accept cycle to meet latency
                        ram_addr  = cpu_addr[RAM_AW+1:2];
                        ram_wdata = cpu_wdata;
                        ram_we    = cpu_we;
                        lat_d     = '0;
                        state_d   = S_RAM_WAIT;
                    end else begin
                        if (!cpu_we)
                            rdata_d = req_hit ? io_rdata : ERR_RDATA;
                        state_d = S_DONE;
                    end
                end
            end
            S_RAM_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    rdata_d = we_q ? 32'h0 : ram_rdata;
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_DONE: begin
                MIO_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic wr_commit, match;
    assign wr_commit = (state_q == S_DONE) && we_q && lat_io;

    always_comb begin
        led_d     = led_q;
        count_d   = count_q;
        compare_d = compare_q;
        ctrl_d    = ctrl_q;
        match     = 1'b0;
        if (ctrl_q[0]) begin
            if ((compare_q != 32'h0) && (count_q == compare_q)) begin
                count_d = '0;
                match   = 1'b1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
        // A set in the same cycle as an acknowledge keeps the request alive
        pend_d = match ? 1'b1 : (INT_ACK ? 1'b0 : pend_q);
        if (wr_commit) begin
            case (lat_off)
                OFF_LED:  led_d     = wdata_q[15:0];
                OFF_CNT:  count_d   = wdata_q;
                OFF_CMP:  compare_d = wdata_q;
                OFF_CTRL: ctrl_d    = wdata_q[1:0];
                default:  ;
            endcase
        end
    end

`ifdef MIO_BUS_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_DONE) begin
            if (!lat_map)
                err_d = 1'b1;
            else if (wr_commit && (lat_off == OFF_STAT))
                err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            lat_q     <= '0;
            led_q     <= RST_LED;
            count_q   <= '0;
            compare_q <= '0;
            ctrl_q    <= '0;
            pend_q    <= 1'b0;
            int_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            lat_q     <= lat_d;
            led_q     <= led_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            pend_q    <= pend_d;
            int_q     <= pend_q & ctrl_q[1];
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign cpu_rdata = rdata_q;
    assign led       = led_q;
    assign INT       = int_q;

endmodule
